banked_register_file: RTL and testbench

//  Parametrised successor of the core integer register file: 2 async read ports, 1 sync write port,
//  x0 hardwired to zero, plus NumBanks register banks selected by an interrupt nesting level.

---
 rtl/register_file_pkg.sv | 21 ++
 rtl/bank_level_ctrl.sv | 85 ++++++++
 rtl/banked_register_file.sv | 99 +++++++++
 tb/tb_banked_register_file.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and types for the banked integer register file, its decode-stage users
// and the interrupt controller that drives bank switching.
package register_file_pkg;

    localparam int unsigned RfDataWidth = 32;
    localparam int unsigned RfNumRegs   = 32;
    localparam int unsigned RfNumBanks  = 4;

    // A single bank still needs a one-bit level so the port never collapses to zero width.
    function automatic int unsigned level_width(input int unsigned num_banks);
        return (num_banks > 2) ? $clog2(num_banks) : 1;
    endfunction

    localparam int unsigned RfAddrWidth  = $clog2(RfNumRegs);
    localparam int unsigned RfLevelWidth = level_width(RfNumBanks);

    typedef logic [RfDataWidth-1:0]  DataT;
    typedef logic [RfAddrWidth-1:0]  AddrT;
    typedef logic [RfLevelWidth-1:0] LevelT;

endpackage

// File: rtl/bank_level_ctrl.sv
// Interrupt nesting level tracker: arbitrates push/pop, keeps the current bank index and
// the sticky overflow/underflow flags, and tells the register array when to copy sp.
module bank_level_ctrl
    import register_file_pkg::*;
#(
    parameter int unsigned NumBanks   = RfNumBanks,
    parameter int unsigned LevelWidth = level_width(NumBanks)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [LevelWidth-1:0] level_o,
    output logic                  copy_en_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    typedef enum logic [1:0] {
        CmdNone,
        CmdPush,
        CmdPop
    } bank_cmd_e;

    localparam logic [LevelWidth-1:0] TopLevel = LevelWidth'(NumBanks - 1);

    bank_cmd_e             cmd;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Simultaneous push and pop cancel out entirely.
    always_comb begin
        cmd = CmdNone;
        if (push_i && !pop_i) begin
            cmd = CmdPush;
        end else if (pop_i && !push_i) begin
            cmd = CmdPop;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        copy_en_o   = 1'b0;
        unique case (cmd)
            CmdPush: begin
                if (level_q == TopLevel) begin
                    overflow_d = 1'b1;
                end else begin
                    level_d   = level_q + LevelWidth'(1);
                    copy_en_o = 1'b1;
                end
            end
            CmdPop: begin
                if (level_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    level_d = level_q - LevelWidth'(1);
                end
            end
            default: ;
        endcase
    end

    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/banked_register_file.sv
// Register file with one bank per interrupt nesting level: two combinational read ports,
// one synchronous write port, x0 reads as zero, sp carried into the new bank on entry.
module banked_register_file
    import register_file_pkg::*;
#(
    parameter int unsigned  DataWidth    = RfDataWidth,
    parameter int unsigned  NumRegs      = RfNumRegs,
    parameter int unsigned  NumBanks     = RfNumBanks,
    parameter int unsigned  WriteThrough = 1,
    parameter int unsigned  SpIndex      = 2,
    localparam int unsigned AddrWidth    = $clog2(NumRegs),
    localparam int unsigned LevelWidth   = level_width(NumBanks)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AddrWidth-1:0]  raddr_a_i,
    output logic [DataWidth-1:0]  rdata_a_o,
    input  logic [AddrWidth-1:0]  raddr_b_i,
    output logic [DataWidth-1:0]  rdata_b_o,
    input  logic [AddrWidth-1:0]  waddr_a_i,
    input  logic [DataWidth-1:0]  wdata_a_i,
    input  logic                  we_a_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [LevelWidth-1:0] level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [AddrWidth-1:0] SpAddr = AddrWidth'(SpIndex);

    logic [DataWidth-1:0]  regs [NumBanks][NumRegs];
    logic [LevelWidth-1:0] level;
    logic [LevelWidth-1:0] next_bank;
    logic                  copy_en;
    logic                  write_en;
    logic [DataWidth-1:0]  sp_value;

    bank_level_ctrl #(
        .NumBanks  (NumBanks),
        .LevelWidth(LevelWidth)
    ) u_level_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .level_o    (level),
        .copy_en_o  (copy_en),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    assign write_en  = we_a_i && (waddr_a_i != '0);
    assign next_bank = level + LevelWidth'(1);

    // The sp copied into the new bank must include a write to sp landing on the same edge.
    assign sp_value = (we_a_i && waddr_a_i == SpAddr) ? wdata_a_i : regs[level][SpAddr];

    function automatic logic [DataWidth-1:0] read_port(
        input logic [AddrWidth-1:0] raddr,
        input logic [DataWidth-1:0] stored,
        input logic                 we,
        input logic [AddrWidth-1:0] waddr,
        input logic [DataWidth-1:0] wdata
    );
        if (raddr == '0) begin
            return '0;
        end
        if (WriteThrough != 0 && we && waddr == raddr) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rdata_a_o = read_port(raddr_a_i, regs[level][raddr_a_i], we_a_i, waddr_a_i, wdata_a_i);
    assign rdata_b_o = read_port(raddr_b_i, regs[level][raddr_b_i], we_a_i, waddr_a_i, wdata_a_i);

    // Writes land in the pre-edge bank; the sp copy targets the bank being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the array is reset because software relies on every bank reading zero after reset.
            for (int b = 0; b < int'(NumBanks); b++) begin
                for (int r = 0; r < int'(NumRegs); r++) begin
                    regs[b][r] <= '0;
                end
            end
        end else begin
            if (write_en) begin
                regs[level][waddr_a_i] <= wdata_a_i;
            end
            if (copy_en) begin
                regs[next_bank][SpAddr] <= sp_value;
            end
        end
    end

    assign level_o = level;

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against an array-based model of the bank rules.
`timescale 1ns/1ps
module tb_banked_register_file;

    localparam int NB = 4;
    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 2;
    localparam int SP = 2;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b1;
    logic [AW-1:0] raddr_a_i = '0;
    logic [AW-1:0] raddr_b_i = '0;
    logic [AW-1:0] waddr_a_i = '0;
    logic [DW-1:0] wdata_a_i = '0;
    logic          we_a_i    = 1'b0;
    logic          push_i    = 1'b0;
    logic          pop_i     = 1'b0;
    logic [DW-1:0] rdata_a_o;
    logic [DW-1:0] rdata_b_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic          underflow_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_regs [NB][NR];
    int            m_level;
    bit            m_ovf;
    bit            m_unf;

    banked_register_file dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .raddr_a_i  (raddr_a_i),
        .rdata_a_o  (rdata_a_o),
        .raddr_b_i  (raddr_b_i),
        .rdata_b_o  (rdata_b_o),
        .waddr_a_i  (waddr_a_i),
        .wdata_a_i  (wdata_a_i),
        .we_a_i     (we_a_i),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: what a read must return given the stored banks and this cycle's write.
    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we_a_i && waddr_a_i == a) return wdata_a_i;
        return m_regs[m_level][a];
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NR; r++)
                    m_regs[b][r] <= '0;
            m_level <= 0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            if (we_a_i && waddr_a_i != 0) m_regs[m_level][waddr_a_i] <= wdata_a_i;
            if (push_i && !pop_i) begin
                if (m_level < NB - 1) begin
                    m_regs[m_level+1][SP] <= (we_a_i && waddr_a_i == AW'(SP)) ? wdata_a_i
                                                                             : m_regs[m_level][SP];
                    m_level <= m_level + 1;
                end else begin
                    m_ovf <= 1'b1;
                end
            end else if (pop_i && !push_i) begin
                if (m_level > 0) m_level <= m_level - 1;
                else m_unf <= 1'b1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            #5;
            check("rdata_a", rdata_a_o, m_read(raddr_a_i));
            check("rdata_b", rdata_b_o, m_read(raddr_b_i));
            check("level", DW'(level_o), DW'(m_level));
            check("overflow", DW'(overflow_o), DW'(m_ovf));
            check("underflow", DW'(underflow_o), DW'(m_unf));
        end
    end

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic push, input logic pop);
        @(negedge clk_i);
        we_a_i    = we;
        waddr_a_i = wa;
        wdata_a_i = wd;
        raddr_a_i = ra;
        raddr_b_i = rb;
        push_i    = push;
        pop_i     = pop;
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        drive(1'b0, '0, '0, ra, rb, 1'b0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;

        // 1. reset state, full read sweep, x0 discard
        #1 rst_ni = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_level", DW'(level_o), 32'd0);
        check("reset_overflow", DW'(overflow_o), 32'd0);
        check("reset_underflow", DW'(underflow_o), 32'd0);
        repeat (2) @(negedge clk_i);
        #4 rst_ni = 1'b1;
        for (int a = 0; a < NR; a++) begin
            idle(AW'(a), AW'(NR - 1 - a));
            #3;
            check("sweep_a", rdata_a_o, 32'd0);
            check("sweep_b", rdata_b_o, 32'd0);
        end
        drive(1'b1, 5'd1, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 32'hffff_ffff, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(5'd0, 5'd1);
        #3;
        check("x0_discard", rdata_a_o, 32'd0);
        check("x1_write", rdata_b_o, 32'h1234_5678);

        // 2. same-cycle forwarding
        drive(1'b1, 5'd31, 32'hdead_beef, 5'd31, 5'd1, 1'b0, 1'b0);
        #3;
        check("forward_a", rdata_a_o, 32'hdead_beef);

        // 3. push copies sp only; pop restores bank 0
        drive(1'b1, 5'd2, 32'h0000_1000, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 32'h0000_0055, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b1, 1'b0);
        idle(5'd2, 5'd5);
        #3;
        check("push_level", DW'(level_o), 32'd1);
        check("push_sp_copy", rdata_a_o, 32'h0000_1000);
        check("push_fresh_x5", rdata_b_o, 32'd0);
        drive(1'b1, 5'd5, 32'h0000_00aa, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(5'd5, 5'd2);
        #3;
        check("pop_level", DW'(level_o), 32'd0);
        check("pop_x5", rdata_a_o, 32'h0000_0055);
        check("pop_x2", rdata_b_o, 32'h0000_1000);

        // 4. push with a simultaneous sp write
        drive(1'b1, 5'd2, 32'h0000_2000, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(5'd2, 5'd5);
        #3;
        check("push_wr_level", DW'(level_o), 32'd1);
        check("push_wr_sp", rdata_a_o, 32'h0000_2000);
        check("bank1_x5_kept", rdata_b_o, 32'h0000_00aa);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(5'd2, 5'd0);
        #3;
        check("bank0_sp", rdata_a_o, 32'h0000_2000);

        // 5. overflow and underflow
        repeat (NB) drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(5'd0, 5'd0);
        #3;
        check("ovf_level", DW'(level_o), 32'd3);
        check("ovf_flag", DW'(overflow_o), 32'd1);
        check("ovf_no_unf", DW'(underflow_o), 32'd0);
        repeat (NB) drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(5'd0, 5'd0);
        #3;
        check("unf_level", DW'(level_o), 32'd0);
        check("unf_flag", DW'(underflow_o), 32'd1);

        // 6. push+pop together, then reset between edges at level 2
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        idle(5'd0, 5'd0);
        #3;
        check("both_level", DW'(level_o), 32'd0);
        check("both_ovf", DW'(overflow_o), 32'd0);
        check("both_unf", DW'(underflow_o), 32'd0);
        repeat (2) drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd7, 32'h0000_0077, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(5'd7, 5'd2);
        #3;
        check("lvl2_level", DW'(level_o), 32'd2);
        check("lvl2_x7", rdata_a_o, 32'h0000_0077);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_level", DW'(level_o), 32'd0);
        check("midrst_x7", rdata_a_o, 32'd0);
        check("midrst_x2", rdata_b_o, 32'd0);
        @(negedge clk_i);
        #4 rst_ni = 1'b1;

        // randomized traffic against the model
        repeat (3000) begin
            wa = AW'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? AW'(SP) : AW'($urandom);
            drive(1'($urandom_range(0, 1)), wa, $urandom, ra, rb,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
        end
        idle(5'd0, 5'd0);
        @(negedge clk_i);
        #6;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
